// File: rtl/serial_word_receiver_if.sv
// Bundle of the serial-receive and word-output signals of serial_word_receiver.
//   ser_in / ser_valid / ser_sof : serial bit, its qualifier, start-of-frame marker
//   out_data / out_perr          : assembled word and its parity-error flag
//   out_valid / out_ready        : output word handshake
//   busy / overrun / frame_err   : status (frame in progress, dropped word, aborted frame)
// master: the side that drives the serial stream and consumes words.
// slave:  the receiver itself.
interface serial_word_receiver_if #(
    parameter int WIDTH = 8
);
    logic             ser_in;
    logic             ser_valid;
    logic             ser_sof;
    logic [WIDTH-1:0] out_data;
    logic             out_perr;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             frame_err;

    modport master (
        output ser_in, ser_valid, ser_sof, out_ready,
        input  out_data, out_perr, out_valid, busy, overrun, frame_err
    );

    modport slave (
        input  ser_in, ser_valid, ser_sof, out_ready,
        output out_data, out_perr, out_valid, busy, overrun, frame_err
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with even-parity check and a one-word output buffer.
// A frame is WIDTH data bits (first one flagged by ser_sof) followed by one parity bit.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   io_bus : serial_word_receiver_if slave modport (serial input, word output, status)
// The interface instance must be built with the same WIDTH as this module.
module serial_word_receiver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_word_receiver_if.slave  io_bus
);
    localparam int CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            r_state;
    logic [CntW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_shift;
    logic              r_par;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_perr;
    logic              r_out_valid;
    logic              r_overrun;
    logic              r_frame_err;

    logic [WIDTH-1:0]  w_shift_next;
    logic [WIDTH-1:0]  w_shift_first;
    logic              w_buf_free;
    logic              w_perr;

    // MSB-first streams enter at the LSB and move up; LSB-first streams enter at the MSB
    // and move down, so after WIDTH bits the first bit sits at its final position.
    assign w_shift_next  = MSB_FIRST ? {r_shift[WIDTH-2:0], io_bus.ser_in}
                                     : {io_bus.ser_in, r_shift[WIDTH-1:1]};
    assign w_shift_first = MSB_FIRST ? {{(WIDTH-1){1'b0}}, io_bus.ser_in}
                                     : {io_bus.ser_in, {(WIDTH-1){1'b0}}};

    // The buffer can take a word if empty or being drained this very cycle.
    assign w_buf_free = !r_out_valid || io_bus.out_ready;
    // r_par is the running XOR of the data bits; folding in the parity bit gives the error.
    assign w_perr     = r_par ^ io_bus.ser_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_out_data  <= '0;
            r_out_perr  <= 1'b0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_out_valid && io_bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (io_bus.ser_valid) begin
                case (r_state)
                    StIdle: begin
                        if (io_bus.ser_sof) begin
                            r_shift <= w_shift_first;
                            r_par   <= io_bus.ser_in;
                            r_cnt   <= CntW'(1);
                            r_state <= StShift;
                        end
                    end
                    StShift: begin
                        if (io_bus.ser_sof) begin
                            // New start of frame wins over any partial frame, even on the
                            // parity-bit slot.
                            r_shift     <= w_shift_first;
                            r_par       <= io_bus.ser_in;
                            r_cnt       <= CntW'(1);
                            r_frame_err <= 1'b1;
                        end else if (r_cnt == LastCnt) begin
                            if (w_buf_free) begin
                                // Overrides the drain-clear above when loading on a handshake.
                                r_out_data  <= r_shift;
                                r_out_perr  <= w_perr;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            r_cnt   <= '0;
                            r_state <= StIdle;
                        end else begin
                            r_shift <= w_shift_next;
                            r_par   <= r_par ^ io_bus.ser_in;
                            r_cnt   <= r_cnt + CntW'(1);
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_perr  = r_out_perr;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.busy      = (r_state == StShift);
    assign io_bus.overrun   = r_overrun;
    assign io_bus.frame_err = r_frame_err;
endmodule

// File: doc/serial_word_receiver.md
SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of data bits per frame (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = first data bit received is bit WIDTH-1; 0 = first data bit received is bit 0.
REQ-003 Port clk, input, 1, clock; all logic SHALL be clocked on the rising edge.
REQ-004 Port rst, input, 1; the block SHALL use a synchronous, active-high reset.
REQ-005 Port ser_in, input, 1, serial data bit.
REQ-006 Port ser_valid, input, 1, qualifies ser_in for the current cycle.
REQ-007 Port ser_sof, input, 1, start of frame; meaningful only when ser_valid=1.
REQ-008 Port out_data, output, WIDTH, assembled data word.
REQ-009 Port out_perr, output, 1, parity error flag for the word on out_data.
REQ-010 Port out_valid, output, 1, out_data and out_perr hold a word.
REQ-011 Port out_ready, input, 1, the consumer accepts the word.
REQ-012 Port busy, output, 1, a frame is partially received.
REQ-013 Port overrun, output, 1, one-cycle pulse: a completed word was dropped.
REQ-014 Port frame_err, output, 1, one-cycle pulse: a frame was aborted by a new start of frame.

Function
REQ-015 Frame format SHALL be: WIDTH data bits followed by one even-parity bit; the first data bit SHALL carry ser_sof=1; only cycles with ser_valid=1 SHALL carry bits.
REQ-016 The FSM SHALL have two states: IDLE and SHIFT. busy SHALL be 1 exactly in SHIFT.
REQ-017 In IDLE: ser_valid=1 with ser_sof=0 SHALL be ignored. ser_valid=1 with ser_sof=1 SHALL store the bit as data bit 0 of the frame, set the bit counter to 1, and go to SHIFT.
REQ-018 In SHIFT: each ser_valid=1 cycle with ser_sof=0 SHALL store the bit and increment the counter. Cycles with ser_valid=0 SHALL hold all state, with no timeout.
REQ-019 When MSB_FIRST=1, data SHALL shift in at the LSB (shift left). When MSB_FIRST=0, data SHALL shift in at the MSB (shift right).
REQ-020 The bit arriving when the counter equals WIDTH SHALL be the parity bit. On that bit the block SHALL complete the word, clear the counter and return to IDLE.
REQ-021 On completion the parity error SHALL be computed as the XOR of all WIDTH data bits and the parity bit (nonzero = error).
REQ-022 When the output buffer is free (out_valid=0, or out_valid=1 with out_ready=1 in the same cycle), completion SHALL load out_data and out_perr and drive out_valid=1 on the next cycle. Latency is one clock from the parity-bit sample.
REQ-023 A completion while out_valid=1 and out_ready=0 SHALL discard the new word, leave out_data and out_perr unchanged, and pulse overrun for one cycle.
REQ-024 out_valid SHALL clear the cycle after out_valid=1 and out_ready=1, unless a new word is loaded in that same cycle.
REQ-025 out_data and out_perr SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 In SHIFT, ser_valid=1 with ser_sof=1 SHALL abort the partial frame and pulse frame_err. The bit SHALL be taken as data bit 0 of a new frame (counter=1, remain in SHIFT).
REQ-027 ser_sof=1 with ser_valid=0 SHALL be ignored in all states.
REQ-028 The shift register and the output buffer SHALL be independent, so a new frame may be received while the previous word awaits out_ready.

Reset
REQ-029 While rst=1 at a clock edge, the next state SHALL be: IDLE, counter=0, shift register=0, out_data=0, out_perr=0, out_valid=0, busy=0, overrun=0, frame_err=0.
REQ-030 Reset SHALL take priority over all other inputs. Reset mid-frame SHALL discard the partial frame with no frame_err pulse.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, out_ready=1: sof plus bits 1,0,1,0,0,1,0,1, then parity 0 -> out_valid=1 one cycle after the parity bit, out_data=0xA5, out_perr=0, busy=0.
REQ-032 WIDTH=8, MSB_FIRST=0: bits 1,0,1,0,0,0,0,0 (LSB first), then parity 1 -> out_data=0x05, out_perr=1.
REQ-033 out_ready=0: send 0x3C (parity 0), then 0xFF (parity 0) -> second completion pulses overrun once; out_data stays 0x3C with out_valid=1.
REQ-034 Same as REQ-033 but raise out_ready exactly on the second parity-bit cycle -> no overrun; out_data=0xFF the next cycle with out_valid=1.
REQ-035 sof plus 3 bits, then sof plus a full 0x81 frame (parity 0) -> frame_err pulses once on the second sof; out_data=0x81, out_perr=0.
REQ-036 Gaps of random ser_valid=0 between bits, then rst asserted after 5 bits -> all outputs 0 the next cycle; a following clean 0x5A frame is received correctly.
